sonar_scheduler: RTL

SONAR_SCHEDULER -- requirements
Module: sonar_scheduler

---
 rtl/sonar_pkg.sv | 23 ++
 rtl/sonar_echo_sync.sv | 23 ++
 rtl/sonar_scheduler.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/sonar_pkg.sv
// Shared FSM state encoding and default timing constants for the sonar ping scheduler.
package sonar_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    GAP
  } state_t;

  localparam int DEF_TRIG_CYCLES  = 1000;
  localparam int DEF_RISE_TIMEOUT = 100000;
  localparam int DEF_ECHO_MAX     = 3000000;
  localparam int DEF_GAP_CYCLES   = 6000000;
  localparam int DEF_CRASH_THRESH = 294117;

  // Increment that holds at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/sonar_echo_sync.sv
// Two-flop synchronizer bank bringing the raw echo lines into the clk domain.
module sonar_echo_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] synced
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta   <= '0;
      synced <= '0;
    end else begin
      meta   <= raw;
      synced <= meta;
    end
  end

endmodule

// File: rtl/sonar_scheduler.sv
// Round-robin ultrasonic ping scheduler: trigger, echo timing, result publish, obstacle flags.
// Define SONAR_CRASH_DEBOUNCE_EN to require two consecutive near results before flagging.
module sonar_scheduler
  import sonar_pkg::*;
#(
  parameter int NUM_SENSORS  = 3,
  parameter int TRIG_CYCLES  = DEF_TRIG_CYCLES,
  parameter int RISE_TIMEOUT = DEF_RISE_TIMEOUT,
  parameter int ECHO_MAX     = DEF_ECHO_MAX,
  parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
  parameter int CRASH_THRESH = DEF_CRASH_THRESH,
  localparam int ID_W        = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [NUM_SENSORS-1:0] echo,
  output logic [NUM_SENSORS-1:0] trigger,
  output logic                   dist_valid,
  output logic [ID_W-1:0]        dist_id,
  output logic [31:0]            dist_value,
  output logic                   dist_timeout,
  output logic [NUM_SENSORS-1:0] is_crash
);

  localparam logic [31:0]     TRIG_LEN  = 32'(TRIG_CYCLES);
  localparam logic [31:0]     RISE_LEN  = 32'(RISE_TIMEOUT);
  localparam logic [31:0]     ECHO_LIM  = 32'(ECHO_MAX);
  localparam logic [31:0]     GAP_LEN   = 32'(GAP_CYCLES);
  localparam logic [31:0]     CRASH_LIM = 32'(CRASH_THRESH);
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_SENSORS - 1);

  function automatic logic [NUM_SENSORS-1:0] onehot(input logic [ID_W-1:0] idx);
    logic [NUM_SENSORS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  logic [NUM_SENSORS-1:0] echo_s;

  sonar_echo_sync #(
    .WIDTH (NUM_SENSORS)
  ) u_echo_sync (
    .clk    (clk),
    .rst    (rst),
    .raw    (echo),
    .synced (echo_s)
  );

  state_t          state;
  logic [ID_W-1:0] sel;
  logic [ID_W-1:0] sel_next;
  logic [31:0]     cnt;
  logic [31:0]     cnt_inc;
  logic            echo_sel;
  logic            pub_now;
  logic [31:0]     pub_val;
  logic            pub_to;
  logic            near;
  logic            crash_set;

  assign echo_sel = echo_s[sel];
  assign cnt_inc  = sat_inc(cnt);
  assign sel_next = (sel == LAST_ID) ? '0 : sel + ID_W'(1);
  assign near     = !pub_to && (pub_val <= CRASH_LIM);

  // Decide whether this cycle ends the ping and what the result is.
  always_comb begin
    pub_now = 1'b0;
    pub_val = '0;
    pub_to  = 1'b0;
    case (state)
      WAIT_RISE: begin
        if (echo_sel) begin
          if (ECHO_LIM <= 32'd1) begin
            pub_now = 1'b1;
            pub_val = ECHO_LIM;
            pub_to  = 1'b1;
          end
        end else if (cnt_inc >= RISE_LEN) begin
          pub_now = 1'b1;
          pub_to  = 1'b1;
        end
      end
      MEASURE: begin
        if (!echo_sel) begin
          pub_now = 1'b1;
          pub_val = cnt;
        end else if (cnt_inc >= ECHO_LIM) begin
          pub_now = 1'b1;
          pub_val = ECHO_LIM;
          pub_to  = 1'b1;
        end
      end
      default: ;
    endcase
  end

`ifdef SONAR_CRASH_DEBOUNCE_EN
  // Per-sensor memory of whether the previous result was near.
  logic [NUM_SENSORS-1:0] near_hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      near_hist <= '0;
    end else if (pub_now) begin
      near_hist[sel] <= near;
    end
  end

  assign crash_set = near && near_hist[sel];
`else
  assign crash_set = near;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      sel          <= '0;
      cnt          <= '0;
      trigger      <= '0;
      dist_valid   <= 1'b0;
      dist_id      <= '0;
      dist_value   <= '0;
      dist_timeout <= 1'b0;
      is_crash     <= '0;
    end else begin
      dist_valid <= 1'b0;
      if (pub_now) begin
        state          <= GAP;
        cnt            <= '0;
        dist_valid     <= 1'b1;
        dist_id        <= sel;
        dist_value     <= pub_val;
        dist_timeout   <= pub_to;
        is_crash[sel]  <= crash_set;
      end else begin
        case (state)
          IDLE: begin
            trigger <= '0;
            cnt     <= '0;
            if (enable) begin
              state   <= TRIG;
              trigger <= onehot(sel);
              cnt     <= 32'd1;
            end
          end
          TRIG: begin
            if (cnt >= TRIG_LEN) begin
              state   <= WAIT_RISE;
              trigger <= '0;
              cnt     <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          WAIT_RISE: begin
            // A line already high on entry counts as the rise in this cycle.
            if (echo_sel) begin
              state <= MEASURE;
              cnt   <= 32'd1;
            end else begin
              cnt <= cnt_inc;
            end
          end
          MEASURE: begin
            cnt <= cnt_inc;
          end
          GAP: begin
            if (cnt_inc >= GAP_LEN) begin
              sel <= sel_next;
              if (enable) begin
                state   <= TRIG;
                trigger <= onehot(sel_next);
                cnt     <= 32'd1;
              end else begin
                state <= IDLE;
                cnt   <= '0;
              end
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: begin
            state   <= IDLE;
            trigger <= '0;
            cnt     <= '0;
          end
        endcase
      end
    end
  end

endmodule
